// File: rtl/rpn_stack_ctrl.sv
// Stack controller for the RPN calculator: sequences reads/writes of an external 8-entry
// register file and tracks the stack depth. Define RPN_MUL_EN to build the MUL operation.
module rpn_stack_ctrl #(
    parameter int k = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [2:0]   op_code,
    input  logic [k-1:0] op_data,
    output logic         done,
    output logic         err,
    output logic [3:0]   sp,
    output logic [2:0]   rf_writenum,
    output logic         rf_write,
    output logic [k-1:0] rf_data_in,
    output logic [7:0]   rf_readsel,
    input  logic [k-1:0] rf_data_out
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WB   = 3'd3,
        WB2  = 3'd4
    } state_t;

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_DUP  = 3'b101;
    localparam logic [2:0] OP_SWAP = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    state_t         state_q, state_d;
    logic [3:0]     sp_q, sp_d;
    logic [2:0]     op_q, op_d;
    logic           fail_q, fail_d;
    logic [k-1:0]   a_q, a_d;
    logic [k-1:0]   b_q, b_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           rf_write_q, rf_write_d;
    logic [2:0]     rf_writenum_q, rf_writenum_d;
    logic [k-1:0]   rf_data_in_q, rf_data_in_d;
    logic [7:0]     rf_readsel_q, rf_readsel_d;
    logic [2:0]     tos_idx_s;
    logic [2:0]     nos_idx_s;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'd1 << idx;
    endfunction

    // Decides at accept whether the op must be rejected for the current depth.
    function automatic logic op_rejected(input logic [2:0] code, input logic [3:0] depth);
        case (code)
            OP_PUSH: op_rejected = (depth == 4'd8);
            OP_POP:  op_rejected = (depth == 4'd0);
            OP_ADD:  op_rejected = (depth < 4'd2);
            OP_SUB:  op_rejected = (depth < 4'd2);
`ifdef RPN_MUL_EN
            OP_MUL:  op_rejected = (depth < 4'd2);
`else
            OP_MUL:  op_rejected = 1'b1;
`endif
            OP_DUP:  op_rejected = (depth == 4'd0) || (depth == 4'd8);
            OP_SWAP: op_rejected = (depth < 4'd2);
            OP_CLR:  op_rejected = 1'b0;
            default: op_rejected = 1'b1;
        endcase
    endfunction

    // sp==8 wraps to index 0 in 3 bits, so sp-1 still addresses entry 7.
    assign tos_idx_s = sp_q[2:0] - 3'd1;
    assign nos_idx_s = sp_q[2:0] - 3'd2;

    assign op_ready    = (state_q == IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign sp          = sp_q;
    assign rf_writenum = rf_writenum_q;
    assign rf_write    = rf_write_q;
    assign rf_data_in  = rf_data_in_q;
    assign rf_readsel  = rf_readsel_q;

    // Next-state, operand capture and next values of all registered outputs.
    always_comb begin
        state_d       = state_q;
        sp_d          = sp_q;
        op_d          = op_q;
        fail_d        = fail_q;
        a_d           = a_q;
        b_d           = b_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        rf_write_d    = 1'b0;
        rf_writenum_d = rf_writenum_q;
        rf_data_in_d  = rf_data_in_q;
        rf_readsel_d  = 8'd1;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    op_d   = op_code;
                    fail_d = op_rejected(op_code, sp_q);
                    if (op_rejected(op_code, sp_q)) begin
                        state_d = WB;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        case (op_code)
                            OP_PUSH: begin
                                state_d       = WB;
                                done_d        = 1'b1;
                                rf_write_d    = 1'b1;
                                rf_writenum_d = sp_q[2:0];
                                rf_data_in_d  = op_data;
                            end
                            OP_POP, OP_CLR: begin
                                state_d = WB;
                                done_d  = 1'b1;
                            end
                            default: begin
                                state_d      = RD_A;
                                rf_readsel_d = onehot8(tos_idx_s);
                            end
                        endcase
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_A: begin
                a_d = rf_data_out;
                if (op_q == OP_DUP) begin
                    state_d       = WB;
                    done_d        = 1'b1;
                    rf_write_d    = 1'b1;
                    rf_writenum_d = sp_q[2:0];
                    rf_data_in_d  = rf_data_out;
                end else begin
                    state_d      = RD_B;
                    rf_readsel_d = onehot8(nos_idx_s);
                end
            end
            RD_B: begin
                // rf_data_out is NOS here; A was captured one cycle earlier.
                b_d           = rf_data_out;
                state_d       = WB;
                done_d        = (op_q != OP_SWAP);
                rf_write_d    = 1'b1;
                rf_writenum_d = nos_idx_s;
                case (op_q)
                    OP_ADD:  rf_data_in_d = rf_data_out + a_q;
                    OP_SUB:  rf_data_in_d = rf_data_out - a_q;
`ifdef RPN_MUL_EN
                    OP_MUL:  rf_data_in_d = rf_data_out * a_q;
`endif
                    default: rf_data_in_d = a_q;
                endcase
            end
            WB: begin
                if ((op_q == OP_SWAP) && !fail_q) begin
                    state_d       = WB2;
                    done_d        = 1'b1;
                    rf_write_d    = 1'b1;
                    rf_writenum_d = tos_idx_s;
                    rf_data_in_d  = b_q;
                end else begin
                    state_d = IDLE;
                    if (!fail_q) begin
                        case (op_q)
                            OP_PUSH, OP_DUP:                 sp_d = sp_q + 4'd1;
                            OP_POP, OP_ADD, OP_SUB, OP_MUL: sp_d = sp_q - 4'd1;
                            OP_CLR:                          sp_d = 4'd0;
                            default:                         sp_d = sp_q;
                        endcase
                    end else begin
                        sp_d = sp_q;
                    end
                end
            end
            WB2: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sp_q          <= 4'd0;
            op_q          <= 3'd0;
            fail_q        <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            rf_write_q    <= 1'b0;
            rf_writenum_q <= 3'd0;
            rf_data_in_q  <= '0;
            rf_readsel_q  <= 8'd1;
        end else begin
            state_q       <= state_d;
            sp_q          <= sp_d;
            op_q          <= op_d;
            fail_q        <= fail_d;
            a_q           <= a_d;
            b_q           <= b_d;
            done_q        <= done_d;
            err_q         <= err_d;
            rf_write_q    <= rf_write_d;
            rf_writenum_q <= rf_writenum_d;
            rf_data_in_q  <= rf_data_in_d;
            rf_readsel_q  <= rf_readsel_d;
        end
    end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Self-checking bench for rpn_stack_ctrl: directed vector table, multi-cycle corner
// sequences and randomized ops against a queue-based stack model.
module tb_rpn_stack_ctrl;

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_DUP  = 3'b101;
    localparam logic [2:0] OP_SWAP = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;
`ifdef RPN_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  op_code = 3'd0;
    logic [15:0] op_data = 16'd0;
    logic        done, err, rf_write;
    logic [3:0]  sp;
    logic [2:0]  rf_writenum;
    logic [15:0] rf_data_in, rf_data_out;
    logic [7:0]  rf_readsel;

    logic [15:0] mem [8];
    int          wr_cnt = 0;
    int          acc_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] model_stk [$];

    always #5 clk = ~clk;

    rpn_stack_ctrl #(.k(16)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_data(op_data), .done(done), .err(err), .sp(sp),
        .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_data_in(rf_data_in),
        .rf_readsel(rf_readsel), .rf_data_out(rf_data_out)
    );

    always_comb begin
        rf_data_out = 16'd0;
        for (int i = 0; i < 8; i++)
            if (rf_readsel[i]) rf_data_out = mem[i];
    end

    always @(posedge clk) begin
        if (rf_write) begin
            mem[rf_writenum] <= rf_data_in;
            wr_cnt <= wr_cnt + 1;
        end
        if (op_valid && op_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Abstract stack semantics: expected error, latency and number of entry writes.
    task automatic model_apply(input logic [2:0] c, input logic [15:0] d,
                               output bit e, output int lat, output int wrs);
        int n;
        logic [15:0] a, b;
        n = model_stk.size();
        e = 1'b0; lat = 1; wrs = 0;
        case (c)
            OP_PUSH: if (n == 8) e = 1; else begin model_stk.push_back(d); wrs = 1; end
            OP_POP:  if (n == 0) e = 1; else void'(model_stk.pop_back());
            OP_CLR:  model_stk.delete();
            OP_DUP:  if (n == 0 || n == 8) e = 1;
                     else begin model_stk.push_back(model_stk[n-1]); lat = 2; wrs = 1; end
            OP_SWAP: if (n < 2) e = 1;
                     else begin
                         a = model_stk[n-1]; model_stk[n-1] = model_stk[n-2]; model_stk[n-2] = a;
                         lat = 4; wrs = 2;
                     end
            default: if (n < 2 || (c == OP_MUL && !MUL_EN)) e = 1;
                     else begin
                         a = model_stk.pop_back();
                         b = model_stk.pop_back();
                         if (c == OP_ADD)      model_stk.push_back(16'(int'(b) + int'(a)));
                         else if (c == OP_SUB) model_stk.push_back(16'(int'(b) - int'(a)));
                         else                  model_stk.push_back(16'(int'(b) * int'(a)));
                         lat = 3; wrs = 1;
                     end
        endcase
    endtask

    // Issue one op, measure accept-to-done latency, return once the DUT is IDLE again.
    task automatic do_op(input logic [2:0] c, input logic [15:0] d,
                         output int lat, output bit e, output int wrs);
        int w0;
        bit seen;
        for (int i = 0; i < 10 && !op_ready; i++) begin @(posedge clk); #1; end
        w0 = wr_cnt;
        op_valid = 1'b1; op_code = c; op_data = d;
        @(posedge clk); #1;
        op_valid = 1'b0;
        lat = 0; e = 1'b0; seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            chk("readsel_onehot", 32'($onehot(rf_readsel)), 32'd1);
            if (done) begin lat = i; e = err; seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("ready_after_op", 32'(op_ready), 32'd1);
        wrs = wr_cnt - w0;
    endtask

    task automatic check_stack(input string tag);
        chk($sformatf("%s_sp", tag), 32'(sp), 32'(model_stk.size()));
        for (int i = 0; i < model_stk.size(); i++)
            chk($sformatf("%s_entry%0d", tag, i), 32'(mem[i]), 32'(model_stk[i]));
    endtask

    task automatic run_checked(input string tag, input logic [2:0] c, input logic [15:0] d);
        int lat, wrs, elat, ewrs;
        bit e, ee;
        model_apply(c, d, ee, elat, ewrs);
        do_op(c, d, lat, e, wrs);
        chk($sformatf("%s_err", tag), 32'(e), 32'(ee));
        chk($sformatf("%s_lat", tag), 32'(lat), 32'(elat));
        chk($sformatf("%s_writes", tag), 32'(wrs), 32'(ewrs));
        check_stack(tag);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] data;
        bit          e;
        int          sp;
        int          lat;
        int          wr;
        logic [15:0] tos;
    } vec_t;

    vec_t vecs [17];

    initial begin
        int lat, wrs, elat, ewrs;
        bit e, ee;
        logic [2:0] c;

        vecs[0]  = '{OP_PUSH, 16'd5,     1'b0, 1, 1, 1, 16'd5};
        vecs[1]  = '{OP_PUSH, 16'd3,     1'b0, 2, 1, 1, 16'd3};
        vecs[2]  = '{OP_SUB,  16'd0,     1'b0, 1, 3, 1, 16'd2};
        vecs[3]  = '{OP_POP,  16'd0,     1'b0, 0, 1, 0, 16'd0};
        vecs[4]  = '{OP_POP,  16'd0,     1'b1, 0, 1, 0, 16'd0};
        vecs[5]  = '{OP_PUSH, 16'hFFFF,  1'b0, 1, 1, 1, 16'hFFFF};
        vecs[6]  = '{OP_PUSH, 16'd2,     1'b0, 2, 1, 1, 16'd2};
        vecs[7]  = '{OP_ADD,  16'd0,     1'b0, 1, 3, 1, 16'h0001};
        vecs[8]  = '{OP_CLR,  16'd0,     1'b0, 0, 1, 0, 16'd0};
        vecs[9]  = '{OP_PUSH, 16'd7,     1'b0, 1, 1, 1, 16'd7};
        vecs[10] = '{OP_PUSH, 16'd9,     1'b0, 2, 1, 1, 16'd9};
        vecs[11] = '{OP_SWAP, 16'd0,     1'b0, 2, 4, 2, 16'd7};
        vecs[12] = '{OP_DUP,  16'd0,     1'b0, 3, 2, 1, 16'd7};
        vecs[13] = '{OP_CLR,  16'd0,     1'b0, 0, 1, 0, 16'd0};
        vecs[14] = '{OP_PUSH, 16'd6,     1'b0, 1, 1, 1, 16'd6};
        vecs[15] = '{OP_PUSH, 16'd7,     1'b0, 2, 1, 1, 16'd7};
`ifdef RPN_MUL_EN
        vecs[16] = '{OP_MUL,  16'd0,     1'b0, 1, 3, 1, 16'd42};
`else
        vecs[16] = '{OP_MUL,  16'd0,     1'b1, 2, 1, 0, 16'd7};
`endif

        // Reset state
        #12;
        chk("rst_sp", 32'(sp), 32'd0);
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_write", 32'(rf_write), 32'd0);
        chk("rst_writenum", 32'(rf_writenum), 32'd0);
        chk("rst_data_in", 32'(rf_data_in), 32'd0);
        chk("rst_readsel", 32'(rf_readsel), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            model_apply(vecs[i].op, vecs[i].data, ee, elat, ewrs);
            do_op(vecs[i].op, vecs[i].data, lat, e, wrs);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].e));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_writes", i), 32'(wrs), 32'(vecs[i].wr));
            chk($sformatf("vec%0d_sp", i), 32'(sp), 32'(vecs[i].sp));
            if (vecs[i].sp > 0)
                chk($sformatf("vec%0d_tos", i), 32'(mem[vecs[i].sp-1]), 32'(vecs[i].tos));
            if (i == 11) chk("swap_entry0", 32'(mem[0]), 32'd9);
            if (i == 12) chk("dup_entry2", 32'(mem[2]), 32'd7);
            check_stack($sformatf("vec%0d", i));
        end

        // Overflow: fill to 8, then PUSH and DUP must be rejected without writing
        run_checked("ovf_clr", OP_CLR, 16'd0);
        for (int i = 0; i < 8; i++) run_checked($sformatf("fill%0d", i), OP_PUSH, 16'(i + 16'h100));
        do_op(OP_PUSH, 16'hDEAD, lat, e, wrs);
        chk("ovf_push_err", 32'(e), 32'd1);
        chk("ovf_push_lat", 32'(lat), 32'd1);
        chk("ovf_push_writes", 32'(wrs), 32'd0);
        chk("ovf_push_sp", 32'(sp), 32'd8);
        run_checked("ovf_dup", OP_DUP, 16'd0);
        run_checked("full_add", OP_ADD, 16'd0);

        // op_valid held high: one accept per IDLE visit
        run_checked("hold_clr", OP_CLR, 16'd0);
        acc_cnt = 0;
        op_valid = 1'b1; op_code = OP_PUSH; op_data = 16'd11;
        repeat (6) @(posedge clk);
        #1;
        op_valid = 1'b0;
        for (int i = 0; i < 3; i++) model_stk.push_back(16'd11);
        chk("hold_accepts", 32'(acc_cnt), 32'd3);
        chk("hold_ready", 32'(op_ready), 32'd1);
        check_stack("hold");

        // Reset in the middle of ADD (state RD_B)
        run_checked("rst_push", OP_PUSH, 16'd2);
        op_valid = 1'b1; op_code = OP_ADD;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_sp", 32'(sp), 32'd0);
        chk("midrst_ready", 32'(op_ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_write", 32'(rf_write), 32'd0);
        model_stk.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_checked("post_rst_pop", OP_POP, 16'd0);

        // Randomized ops against the stack model
        for (int i = 0; i < 400; i++) begin
            c = 3'($urandom_range(0, 7));
            if (c == OP_CLR && $urandom_range(0, 3) != 0) c = OP_PUSH;
            run_checked($sformatf("rnd%0d", i), c, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
